// File: rtl/hamming_enc_ctrl_pkg.sv
// Shared types and constants for the Hamming(16,11) encoder controller and its ALU.
package hamming_enc_ctrl_pkg;

  typedef enum logic [2:0] {
    kADD = 3'd0,
    kSUB = 3'd1,
    kAND = 3'd2,
    kOR  = 3'd3,
    kXOR = 3'd4,
    kPAR = 3'd5
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } henc_state_t;

  localparam int unsigned HENC_STEPS = 10;
  localparam logic [3:0]  HENC_LAST  = 4'(HENC_STEPS - 1);

  // Mask pairs indexed by step/2: p8, p4, p2, p1, overall data parity.
  localparam logic [4:0][7:0] HENC_MASK_HI = {8'hFE, 8'hAA, 8'hCC, 8'hF0, 8'hFE};
  localparam logic [4:0][7:0] HENC_MASK_LO = {8'h0F, 8'h0B, 8'h0D, 8'h0E, 8'h00};

  function automatic logic [7:0] henc_mask(input logic [2:0] pair, input logic lo);
    if (pair > 3'd4) return 8'h00;
    return lo ? HENC_MASK_LO[pair] : HENC_MASK_HI[pair];
  endfunction

endpackage

// File: rtl/hamming_enc_ctrl_alu.sv
// Small 8-bit ALU shared across the codebase; the encoder only uses its PAR operation.
module hamming_enc_ctrl_alu
  import hamming_enc_ctrl_pkg::*;
(
  input  logic [7:0] InputA,
  input  logic [7:0] InputB,
  input  alu_op_t    Op,
  output logic [7:0] Out,
  output logic       Zero,
  output logic       Parity
);

  always_comb begin
    Out = 8'h00;
    unique case (Op)
      kADD:    Out = InputA + InputB;
      kSUB:    Out = InputA - InputB;
      kAND:    Out = InputA & InputB;
      kOR:     Out = InputA | InputB;
      kXOR:    Out = InputA ^ InputB;
      kPAR:    Out = {7'b0, ^(InputA & InputB)};
      default: Out = 8'h00;
    endcase
  end

  assign Zero   = (Out == 8'h00);
  assign Parity = ^Out;

endmodule

// File: rtl/hamming_enc_ctrl.sv
// Sequenced Hamming(16,11) encoder: ten PAR steps on a shared ALU build the parity bits.
// Optional feature: define HENC_ABORT_EN to add the Abort input.
module hamming_enc_ctrl
  import hamming_enc_ctrl_pkg::*;
#(
  parameter int unsigned OUT_HOLD = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [10:0] DataIn,
`ifdef HENC_ABORT_EN
  input  logic        Abort,
`endif
  output logic        Busy,
  output logic        Done,
  output logic [15:0] CodeOut
);

  henc_state_t state_q, state_d;
  logic [3:0]  step_q, step_d;
  logic [7:0]  hi_q, hi_d, lo_q, lo_d;
  logic        acc_q, acc_d;
  logic [3:0]  par_q, par_d;
  logic [15:0] code_q, code_d;

  logic [7:0]  alu_a, alu_b, alu_out;
  logic [2:0]  pair;
  logic        dpar, p0;
  logic [15:0] codeword;
  logic        unused_zero, unused_parity, unused_out_hi;

  hamming_enc_ctrl_alu u_alu (
    .InputA (alu_a),
    .InputB (alu_b),
    .Op     (kPAR),
    .Out    (alu_out),
    .Zero   (unused_zero),
    .Parity (unused_parity)
  );

  assign unused_out_hi = ^alu_out[7:1];

  always_comb begin
    pair  = step_q[3:1];
    alu_a = step_q[0] ? lo_q : hi_q;
    alu_b = henc_mask(pair, step_q[0]);
    dpar  = acc_q ^ alu_out[0];
    // Only meaningful at step 9, where dpar is the overall data parity.
    p0       = dpar ^ (^par_q);
    codeword = {hi_q[7:1], par_q[3], lo_q[3:1], par_q[2], lo_q[0], par_q[1], par_q[0], p0};
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    acc_d   = acc_q;
    par_d   = par_q;
    code_d  = code_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = RUN;
          step_d  = 4'd0;
          hi_d    = {DataIn[10:4], 1'b0};
          lo_d    = {4'b0, DataIn[3:0]};
          if (OUT_HOLD == 0) code_d = 16'h0000;
        end
      end
      RUN: begin
        if (!step_q[0]) begin
          acc_d = alu_out[0];
        end else if (pair != 3'd4) begin
          // p8, p4, p2, p1 shift in so par_q ends as {p8, p4, p2, p1}.
          par_d = {par_q[2:0], dpar};
        end
        if (step_q == HENC_LAST) begin
          state_d = DONE;
          step_d  = 4'd0;
          code_d  = codeword;
        end else begin
          step_d = step_q + 4'd1;
        end
`ifdef HENC_ABORT_EN
        if (Abort) begin
          state_d = IDLE;
          step_d  = 4'd0;
          code_d  = code_q;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      step_q  <= 4'd0;
      hi_q    <= 8'h00;
      lo_q    <= 8'h00;
      acc_q   <= 1'b0;
      par_q   <= 4'h0;
      code_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      acc_q   <= acc_d;
      par_q   <= par_d;
      code_q  <= code_d;
    end
  end

  assign Busy    = (state_q == RUN);
  assign Done    = (state_q == DONE);
  assign CodeOut = code_q;

endmodule
